// File: rtl/pipe_pkg.sv
// Shared encodings and control-group types for the RV32I pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
    } ctrl_t;

    // A bubble must never write the register file or memory, nor redirect the PC.
    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        mem_read:    1'b0,
        jump:        1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        result_src:  RES_ALU,
        alu_control: ALU_ADD
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and the fetch/decode stall request.
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            rst_i,
    input  logic            valid_d_i,
    input  logic            valid_e_i,
    input  logic            mem_read_e_i,
    input  logic [RA_W-1:0] rd_e_i,
    input  logic [RA_W-1:0] rs1_d_i,
    input  logic [RA_W-1:0] rs2_d_i,
    input  logic            flush_e_i,
    input  logic            hold_e_i,
    output logic            lu_o,
    output logic            stall_f_o,
    output logic            stall_d_o
);

    logic rd_nonzero;
    logic rs_match;
    logic stall;

    // Source fields are compared regardless of format; a false match only costs a bubble.
    assign rd_nonzero = (rd_e_i != '0);
    assign rs_match   = (rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i);
    assign lu_o       = valid_d_i & valid_e_i & mem_read_e_i & rd_nonzero & rs_match;

    assign stall     = rst_i & ((lu_o & ~flush_e_i) | hold_e_i);
    assign stall_f_o = stall;
    assign stall_d_o = stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemReadD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  RdD,
    input  logic             ValidD,
    input  logic             FlushE,
    input  logic             HoldE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             MemReadE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic             ValidE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [RA_W-1:0]  Rs1E,
    output logic [RA_W-1:0]  Rs2E,
    output logic [RA_W-1:0]  RdE,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCount
);

    // Flow control: the decode slot advances into EX on every edge unless StallD is high,
    // in which case IF/ID must re-present the same instruction; HoldE freezes EX outright.
    ctrl_t            ctrl_in;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             data_en;
    logic             lu;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rd1_q, rd2_q, pc_q, pc_plus4_q, imm_q;
    logic [RA_W-1:0]  rs1_q, rs2_q, rd_q;

    assign ctrl_in = '{
        reg_write:   RegWriteD,
        mem_write:   MemWriteD,
        mem_read:    MemReadD,
        jump:        JumpD,
        branch:      BranchD,
        alu_src:     ALUSrcD,
        result_src:  result_src_e'(ResultSrcD),
        alu_control: alu_ctrl_e'(ALUControlD)
    };

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .rst_i        (rst),
        .valid_d_i    (ValidD),
        .valid_e_i    (valid_q),
        .mem_read_e_i (ctrl_q.mem_read),
        .rd_e_i       (rd_q),
        .rs1_d_i      (Rs1D),
        .rs2_d_i      (Rs2D),
        .flush_e_i    (FlushE),
        .hold_e_i     (HoldE),
        .lu_o         (lu),
        .stall_f_o    (StallF),
        .stall_d_o    (StallD)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        data_en = 1'b0;
        if (FlushE) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            data_en = 1'b1;
        end else if (HoldE) begin
            data_en = 1'b0;
        end else if (lu) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            data_en = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ctrl_d  = ValidD ? ctrl_in : CTRL_BUBBLE;
            valid_d = ValidD;
            data_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q      <= CTRL_BUBBLE;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (data_en) begin
                rd1_q      <= RD1D;
                rd2_q      <= RD2D;
                pc_q       <= PCD;
                pc_plus4_q <= PCPlus4D;
                imm_q      <= ImmExtD;
                rs1_q      <= Rs1D;
                rs2_q      <= Rs2D;
                rd_q       <= RdD;
            end
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign MemReadE    = ctrl_q.mem_read;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign ValidE      = valid_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ImmExtE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts E/stall/counter every cycle.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 2;
    localparam int DW    = 5 * XLEN + 3 * RA_W;

    typedef struct packed {
        logic             known;
        logic [CNT_W-1:0] cnt;
        logic [11:0]      ctrl;
        logic [DW-1:0]    data;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic rst, FlushE, HoldE;
    logic RegWriteD, MemWriteD, MemReadD, JumpD, BranchD, ALUSrcD, ValidD;
    logic [1:0] ResultSrcD;
    logic [2:0] ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [RA_W-1:0] Rs1D, Rs2D, RdD;
    logic RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0] ResultSrcE;
    logic [2:0] ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [RA_W-1:0] Rs1E, Rs2E, RdE;
    logic StallF, StallD;
    logic [CNT_W-1:0] BubbleCount;

    logic [11:0]      e_ctrl;
    logic [DW-1:0]    e_data;
    logic [11:0]      d_ctrl;
    logic [DW-1:0]    d_data;
    logic [EXP_W-1:0] exp_q[$];
    exp_t             m;
    bit               started = 0;
    int               tests_run = 0;
    int               tests_failed = 0;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemReadD(MemReadD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
        .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ValidE(ValidE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallF(StallF), .StallD(StallD), .BubbleCount(BubbleCount)
    );

    // Clock and watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    assign e_ctrl = {RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ALUSrcE,
                     ResultSrcE, ALUControlE, ValidE};
    assign e_data = {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ctrl bit order: RegWrite MemWrite MemRead Jump Branch ALUSrc ResultSrc[1:0] ALUControl[2:0] Valid
    function automatic logic [11:0] ctl(input logic rw, mw, mr, j, b, as,
                                        input logic [1:0] rs, input logic [2:0] ac,
                                        input logic v);
        return {rw, mw, mr, j, b, as, rs, ac, v};
    endfunction

    function automatic logic [DW-1:0] dat(input logic [RA_W-1:0] rs1, rs2, rd);
        logic [XLEN-1:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        return {$urandom(), $urandom(), pc, pc + 32'd4, $urandom(), rs1, rs2, rd};
    endfunction

    task automatic drive_d(input logic [11:0] c, input logic [DW-1:0] dt);
        d_ctrl = c;
        d_data = dt;
        {RegWriteD, MemWriteD, MemReadD, JumpD, BranchD, ALUSrcD,
         ResultSrcD, ALUControlD, ValidD} = c;
        {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = dt;
    endtask

    // One clock: check stalls and stability mid-cycle, push prediction, pop after the edge.
    task automatic step(input logic r, input logic f, input logic h);
        logic lu_m, stall_m;
        logic [RA_W-1:0] rd_e;
        exp_t n, got;
        @(negedge clk);
        rst = r; FlushE = f; HoldE = h;
        #1;
        rd_e = m.data[RA_W-1:0];
        lu_m = d_ctrl[0] & m.ctrl[0] & m.ctrl[9] & (rd_e != 0) &
               ((rd_e == d_data[3*RA_W-1:2*RA_W]) | (rd_e == d_data[2*RA_W-1:RA_W]));
        stall_m = r & ((lu_m & ~f) | h);
        check("stallf", StallF, stall_m);
        check("stalld", StallD, stall_m);
        if (started) check("ctrl_mid", e_ctrl, m.ctrl);
        n = m;
        if (!r) begin
            n = '0;
            n.known = 1'b1;
        end else if (f) begin
            n.ctrl = '0; n.data = d_data; n.known = 1'b0;
        end else if (h) begin
            n = m;
        end else if (lu_m) begin
            n.ctrl = '0; n.data = d_data; n.known = 1'b0;
            if (m.cnt != '1) n.cnt = m.cnt + 1'b1;
        end else begin
            n.ctrl = d_ctrl[0] ? d_ctrl : 12'h0;
            n.data = d_data; n.known = 1'b1;
        end
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("ctrl", e_ctrl, got.ctrl);
            check("cnt", BubbleCount, got.cnt);
            if (got.known) check("data", e_data, got.data);
            m = got;
            started = 1;
        end
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};
        m = '0;
        rst = 1'b0; FlushE = 1'b0; HoldE = 1'b0;
        drive_d('1, '1);

        // Reset with all-ones decode, then with flush/hold asserted: reset wins
        step(0, 0, 0);
        step(0, 1, 1);
        check("rst_valid", ValidE, 0);
        check("rst_cnt", BubbleCount, 0);
        step(1, 0, 0);
        check("rst_capture", e_ctrl, 12'hFFF);

        // Load-use: lw x5 then add using x5
        drive_d(ctl(1, 0, 1, 0, 0, 1, 2'd1, 3'd0, 1), dat(5'd2, 5'd0, 5'd5));
        step(1, 0, 0);
        drive_d(ctl(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1), dat(5'd5, 5'd3, 5'd6));
        step(1, 0, 0);
        check("lu_valid", ValidE, 0);
        check("lu_regwrite", RegWriteE, 0);
        check("lu_cnt", BubbleCount, 1);
        step(1, 0, 0);
        check("lu_advance", RdE, 6);

        // Load to x0 never stalls
        drive_d(ctl(1, 0, 1, 0, 0, 1, 2'd1, 3'd0, 1), dat(5'd1, 5'd0, 5'd0));
        step(1, 0, 0);
        drive_d(ctl(1, 0, 0, 0, 0, 0, 2'd0, 3'd1, 1), dat(5'd0, 5'd0, 5'd7));
        step(1, 0, 0);
        check("x0_valid", ValidE, 1);

        // Flush beats a simultaneous load-use
        drive_d(ctl(1, 0, 1, 0, 0, 1, 2'd1, 3'd0, 1), dat(5'd1, 5'd0, 5'd7));
        step(1, 0, 0);
        drive_d(ctl(0, 1, 0, 0, 0, 1, 2'd0, 3'd0, 1), dat(5'd2, 5'd7, 5'd0));
        step(1, 1, 0);
        check("flush_valid", ValidE, 0);
        check("flush_cnt", BubbleCount, 1);

        // Hold for three cycles with changing decode
        drive_d(ctl(1, 0, 0, 1, 0, 0, 2'd2, 3'd0, 1), dat(5'd3, 5'd4, 5'd8));
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_d(ctl(1, 1, 1, 1, 1, 1, 2'd1, 3'd5, 1), dat(5'd8, 5'd9, 5'd10));
            step(1, 0, 1);
        end

        // Load-use during hold: bubble lands on the first non-hold edge
        drive_d(ctl(1, 0, 1, 0, 0, 1, 2'd1, 3'd0, 1), dat(5'd1, 5'd0, 5'd9));
        step(1, 0, 0);
        drive_d(ctl(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1), dat(5'd4, 5'd9, 5'd11));
        step(1, 0, 1);
        check("luhold_cnt", BubbleCount, 1);
        step(1, 0, 0);
        check("luhold_cnt2", BubbleCount, 2);

        // Random traffic on a small register set
        for (int i = 0; i < 60; i++) begin
            logic [11:0] c;
            c = 12'($urandom_range(0, 4095));
            c[0] = ($urandom_range(0, 3) != 0);
            drive_d(c, dat(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3))));
            step(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // Counter saturation
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_d(ctl(1, 0, 1, 0, 0, 1, 2'd1, 3'd0, 1), dat(5'd0, 5'd0, 5'(i + 1)));
            step(1, 0, 0);
            drive_d(ctl(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1), dat(5'(i + 1), 5'd0, 5'd12));
            step(1, 0, 0);
            check("sat_cnt", BubbleCount, sat_exp[i]);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
